// File: rtl/sifreleme_cozucu_boruhatti.sv
// sifreleme_cozucu_boruhatti
// Decode-and-issue stage placed in front of the combinational sifreleme_birimi.
// It recognises the custom crypto instructions, holds one instruction in an
// issue slot (stage A) whose registers feed the unit directly, and captures
// the unit's answer in a result slot (stage B) that is handed to writeback.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   buyruk_gecerli_i/_hazir_o, buyruk_i, rs1_deger_i, rs2_deger_i
//                          upstream instruction handshake and operands
//   kontrol_o, deger1_o, deger2_o
//                          registered operation and operands to sifreleme_birimi
//   sonuc_i                combinational result from sifreleme_birimi
//   sonuc_gecerli_o/sonuc_hazir_i, sonuc_o, rd_o
//                          writeback handshake, registered result and destination
//   gecersiz_o             one-cycle pulse when an illegal instruction is dropped
//   tamamlanan_o           saturating count of results taken by writeback
//   gecersiz_sayac_o       saturating count of dropped illegal instructions

`ifndef SIFRELEME_HMDST
`define SIFRELEME_HMDST 3'd0
`endif
`ifndef SIFRELEME_PKG
`define SIFRELEME_PKG   3'd1
`endif
`ifndef SIFRELEME_RVRS
`define SIFRELEME_RVRS  3'd2
`endif
`ifndef SIFRELEME_SLADD
`define SIFRELEME_SLADD 3'd3
`endif
`ifndef SIFRELEME_CNTZ
`define SIFRELEME_CNTZ  3'd4
`endif
`ifndef SIFRELEME_CNTP
`define SIFRELEME_CNTP  3'd5
`endif

module sifreleme_cozucu_boruhatti #(
    parameter int SAYAC_BIT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 buyruk_gecerli_i,
    output logic                 buyruk_hazir_o,
    input  logic [31:0]          buyruk_i,
    input  logic [31:0]          rs1_deger_i,
    input  logic [31:0]          rs2_deger_i,
    output logic [2:0]           kontrol_o,
    output logic [31:0]          deger1_o,
    output logic [31:0]          deger2_o,
    input  logic [31:0]          sonuc_i,
    output logic                 sonuc_gecerli_o,
    input  logic                 sonuc_hazir_i,
    output logic [31:0]          sonuc_o,
    output logic [4:0]           rd_o,
    output logic                 gecersiz_o,
    output logic [SAYAC_BIT-1:0] tamamlanan_o,
    output logic [SAYAC_BIT-1:0] gecersiz_sayac_o
);

    localparam logic [6:0] OPCODE_OZEL = 7'b0001011;
    localparam logic [6:0] FUNCT7_KRIPTO = 7'b0000100;
    localparam logic [SAYAC_BIT-1:0] SAYAC_BIR = SAYAC_BIT'(1);
    localparam logic [SAYAC_BIT-1:0] SAYAC_DOLU = '1;

    logic       yasal;
    logic       tekli;
    logic [2:0] islem;
    logic [4:0] hedef;

    logic       a_gecerli;
    logic [4:0] a_rd;
    logic       b_gecerli;

    logic       b_ilerler;
    logic       a_tasinir;
    logic       kabul;
    logic       a_yukle;

    // rs1/rs2 index fields are not needed here; operand values arrive already read
    logic       unused_rs_alanlari;
    assign unused_rs_alanlari = ^buyruk_i[24:15];

    assign hedef = buyruk_i[11:7];

    // Instruction decode. Only the custom opcode with the crypto funct7 is
    // accepted; funct3 selects the unit operation. Unary operations ignore rs2,
    // so their second operand is forced to zero when registered.
    always_comb begin
        yasal = 1'b0;
        tekli = 1'b0;
        islem = `SIFRELEME_HMDST;
        if (buyruk_i[6:0] == OPCODE_OZEL && buyruk_i[31:25] == FUNCT7_KRIPTO) begin
            case (buyruk_i[14:12])
                3'b000: begin yasal = 1'b1; islem = `SIFRELEME_HMDST; end
                3'b001: begin yasal = 1'b1; islem = `SIFRELEME_PKG;   end
                3'b010: begin yasal = 1'b1; islem = `SIFRELEME_RVRS;  tekli = 1'b1; end
                3'b011: begin yasal = 1'b1; islem = `SIFRELEME_SLADD; end
                3'b100: begin yasal = 1'b1; islem = `SIFRELEME_CNTZ;  tekli = 1'b1; end
                3'b101: begin yasal = 1'b1; islem = `SIFRELEME_CNTP;  tekli = 1'b1; end
                default: begin yasal = 1'b0; end
            endcase
        end
    end

    // Handshake chain. Readiness ripples back from writeback in the same cycle,
    // so a full pipeline that is draining still accepts a new instruction.
    assign b_ilerler      = !b_gecerli || sonuc_hazir_i;
    assign a_tasinir      = a_gecerli && b_ilerler;
    assign buyruk_hazir_o = !a_gecerli || a_tasinir;
    assign kabul          = buyruk_gecerli_i && buyruk_hazir_o;
    assign a_yukle        = kabul && yasal;

    assign sonuc_gecerli_o = b_gecerli;

    // Issue slot payload. These registers drive the unit directly and simply
    // keep their last contents while the slot is empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kontrol_o <= 3'd0;
            deger1_o  <= 32'h0;
            deger2_o  <= 32'h0;
            a_rd      <= 5'd0;
        end else if (a_yukle) begin
            kontrol_o <= islem;
            deger1_o  <= rs1_deger_i;
            deger2_o  <= tekli ? 32'h0 : rs2_deger_i;
            a_rd      <= hedef;
        end
    end

    // Occupancy of both slots. A new load into A and a move out of A may
    // happen in the same cycle; B likewise may drain and refill together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_gecerli <= 1'b0;
            b_gecerli <= 1'b0;
        end else begin
            a_gecerli <= a_yukle || (a_gecerli && !a_tasinir);
            b_gecerli <= a_tasinir || (b_gecerli && !sonuc_hazir_i);
        end
    end

    // Result slot payload, captured from the unit as the instruction leaves A.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sonuc_o <= 32'h0;
            rd_o    <= 5'd0;
        end else if (a_tasinir) begin
            sonuc_o <= sonuc_i;
            rd_o    <= a_rd;
        end
    end

    // Illegal-instruction pulse and the two saturating statistics counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gecersiz_o       <= 1'b0;
            tamamlanan_o     <= '0;
            gecersiz_sayac_o <= '0;
        end else begin
            gecersiz_o <= kabul && !yasal;
            if (kabul && !yasal && gecersiz_sayac_o != SAYAC_DOLU) begin
                gecersiz_sayac_o <= gecersiz_sayac_o + SAYAC_BIR;
            end
            if (b_gecerli && sonuc_hazir_i && tamamlanan_o != SAYAC_DOLU) begin
                tamamlanan_o <= tamamlanan_o + SAYAC_BIR;
            end
        end
    end

endmodule

// File: tb/tb_sifreleme_cozucu_boruhatti.sv
// tb_sifreleme_cozucu_boruhatti
// Self-checking bench for the crypto decode/issue stage. A behavioural model
// of sifreleme_birimi closes the loop from kontrol/deger outputs to sonuc_i,
// and an in-order two-slot queue model predicts every output each cycle.
// Counters are narrowed to 4 bits so saturation is reached quickly.

`ifndef SIFRELEME_HMDST
`define SIFRELEME_HMDST 3'd0
`endif
`ifndef SIFRELEME_PKG
`define SIFRELEME_PKG   3'd1
`endif
`ifndef SIFRELEME_RVRS
`define SIFRELEME_RVRS  3'd2
`endif
`ifndef SIFRELEME_SLADD
`define SIFRELEME_SLADD 3'd3
`endif
`ifndef SIFRELEME_CNTZ
`define SIFRELEME_CNTZ  3'd4
`endif
`ifndef SIFRELEME_CNTP
`define SIFRELEME_CNTP  3'd5
`endif

module tb_sifreleme_cozucu_boruhatti;

    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;
    localparam logic [6:0] OPC = 7'b0001011;
    localparam logic [6:0] F7 = 7'b0000100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          buyruk_gecerli;
    logic          buyruk_hazir;
    logic [31:0]   buyruk;
    logic [31:0]   rs1;
    logic [31:0]   rs2;
    logic [2:0]    kontrol;
    logic [31:0]   deger1;
    logic [31:0]   deger2;
    logic [31:0]   sonuc_in;
    logic          sonuc_gecerli;
    logic          sonuc_hazir;
    logic [31:0]   sonuc;
    logic [4:0]    rd;
    logic          gecersiz;
    logic [CW-1:0] tamamlanan;
    logic [CW-1:0] gecersiz_sayac;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] res;
        logic [4:0]  rd;
        bit          in_b;
    } entry_t;

    entry_t q[$];
    bit m_gec;
    int m_comp;
    int m_ill;

    always #5 clk = ~clk;

    sifreleme_cozucu_boruhatti #(.SAYAC_BIT(CW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .buyruk_gecerli_i (buyruk_gecerli),
        .buyruk_hazir_o   (buyruk_hazir),
        .buyruk_i         (buyruk),
        .rs1_deger_i      (rs1),
        .rs2_deger_i      (rs2),
        .kontrol_o        (kontrol),
        .deger1_o         (deger1),
        .deger2_o         (deger2),
        .sonuc_i          (sonuc_in),
        .sonuc_gecerli_o  (sonuc_gecerli),
        .sonuc_hazir_i    (sonuc_hazir),
        .sonuc_o          (sonuc),
        .rd_o             (rd),
        .gecersiz_o       (gecersiz),
        .tamamlanan_o     (tamamlanan),
        .gecersiz_sayac_o (gecersiz_sayac)
    );

    function automatic int popcount(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int trailing_zeros(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 32;
    endfunction

    function automatic logic [31:0] reverse_bits(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Behaviour of the downstream crypto unit
    function automatic logic [31:0] unit_fn(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b);
        case (k)
            `SIFRELEME_HMDST: return 32'(popcount(a ^ b));
            `SIFRELEME_PKG:   return {b[15:0], a[15:0]};
            `SIFRELEME_RVRS:  return reverse_bits(a);
            `SIFRELEME_SLADD: return (a << 1) + b;
            `SIFRELEME_CNTZ:  return 32'(trailing_zeros(a));
            `SIFRELEME_CNTP:  return 32'(popcount(a));
            default:          return 32'h0;
        endcase
    endfunction

    assign sonuc_in = unit_fn(kontrol, deger1, deger2);

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] opc, input logic [9:0] rsf);
        return {f7, rsf, f3, d, opc};
    endfunction

    // Reference decode: returns legality and the operation for a raw word
    function automatic bit ref_decode(input logic [31:0] ins, output logic [2:0] op);
        logic [2:0] table_ops [6] = '{`SIFRELEME_HMDST, `SIFRELEME_PKG, `SIFRELEME_RVRS,
                                      `SIFRELEME_SLADD, `SIFRELEME_CNTZ, `SIFRELEME_CNTP};
        int f3;
        op = 3'd0;
        f3 = int'(ins[14:12]);
        if (ins[6:0] != OPC || ins[31:25] != F7 || f3 > 5) return 0;
        op = table_ops[f3];
        return 1;
    endfunction

    function automatic bit is_unary(input logic [2:0] op);
        return op == `SIFRELEME_RVRS || op == `SIFRELEME_CNTZ || op == `SIFRELEME_CNTP;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, input logic h);
        buyruk_gecerli = v;
        buyruk = ins;
        rs1 = a;
        rs2 = b;
        sonuc_hazir = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Two-slot in-order model: head entry with in_b=1 is the result slot,
    // a trailing entry with in_b=0 is the issue slot.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_gec = 0;
            m_comp = 0;
            m_ill = 0;
        end else begin
            bit bv, ae, amove, acc, legal;
            logic [2:0] op;
            entry_t e;
            bv = q.size() > 0 && q[0].in_b;
            ae = q.size() > 0 && !q[q.size()-1].in_b;
            amove = ae && (!bv || sonuc_hazir);
            acc = buyruk_gecerli && (!ae || amove);
            if (bv && sonuc_hazir) begin
                void'(q.pop_front());
                if (m_comp < SAT) m_comp++;
            end
            if (amove) q[q.size()-1].in_b = 1;
            m_gec = 0;
            if (acc) begin
                legal = ref_decode(buyruk, op);
                if (legal) begin
                    e.op = op;
                    e.d1 = rs1;
                    e.d2 = is_unary(op) ? 32'h0 : rs2;
                    e.res = unit_fn(op, rs1, rs2);
                    e.rd = buyruk[11:7];
                    e.in_b = 0;
                    q.push_back(e);
                end else begin
                    m_gec = 1;
                    if (m_ill < SAT) m_ill++;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            bit bv, ae;
            bv = q.size() > 0 && q[0].in_b;
            ae = q.size() > 0 && !q[q.size()-1].in_b;
            checkOutput("sonuc_gecerli", 32'(sonuc_gecerli), 32'(bv));
            if (bv) begin
                checkOutput("sonuc", sonuc, q[0].res);
                checkOutput("rd", 32'(rd), 32'(q[0].rd));
            end
            if (ae) begin
                checkOutput("kontrol", 32'(kontrol), 32'(q[q.size()-1].op));
                checkOutput("deger1", deger1, q[q.size()-1].d1);
                checkOutput("deger2", deger2, q[q.size()-1].d2);
            end
            checkOutput("buyruk_hazir", 32'(buyruk_hazir), 32'(!ae || !bv || sonuc_hazir));
            checkOutput("gecersiz", 32'(gecersiz), 32'(m_gec));
            checkOutput("tamamlanan", 32'(tamamlanan), 32'(m_comp));
            checkOutput("gecersiz_sayac", 32'(gecersiz_sayac), 32'(m_ill));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 1);
        #1;
        checkOutput("rst_gecerli", 32'(sonuc_gecerli), 32'h0);
        checkOutput("rst_gecersiz", 32'(gecersiz), 32'h0);
        checkOutput("rst_tamamlanan", 32'(tamamlanan), 32'h0);
        checkOutput("rst_sayac", 32'(gecersiz_sayac), 32'h0);
        checkOutput("rst_kontrol", 32'(kontrol), 32'h0);
        checkOutput("rst_deger1", deger1, 32'h0);
        checkOutput("rst_sonuc", sonuc, 32'h0);
        checkOutput("rst_rd", 32'(rd), 32'h0);
        tick();
        rst_n = 1'b1;
        chk_en = 1;

        // HMDST: popcount(f0f0f0f0 ^ fff0f0f0) = 4
        applyStimulus(1, enc(F7, 3'b000, 5'd5, OPC, 10'h0), 32'hf0f0_f0f0, 32'hfff0_f0f0, 1);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 1);
        mid();
        checkOutput("hmdst_kontrol", 32'(kontrol), 32'(`SIFRELEME_HMDST));
        tick();
        mid();
        checkOutput("hmdst_gecerli", 32'(sonuc_gecerli), 32'h1);
        checkOutput("hmdst_sonuc", sonuc, 32'd4);
        checkOutput("hmdst_rd", 32'(rd), 32'd5);
        tick();
        mid();
        checkOutput("hmdst_tamamlanan", 32'(tamamlanan), 32'd1);

        // CNTZ then RVRS back to back
        tick();
        applyStimulus(1, enc(F7, 3'b100, 5'd7, OPC, 10'h0), 32'hffff_0000, 32'h1234_5678, 1);
        tick();
        applyStimulus(1, enc(F7, 3'b010, 5'd8, OPC, 10'h0), 32'hffff_0000, 32'haaaa_5555, 1);
        mid();
        checkOutput("cntz_deger2", deger2, 32'h0);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 1);
        mid();
        checkOutput("cntz_sonuc", sonuc, 32'd16);
        checkOutput("rvrs_deger2", deger2, 32'h0);
        tick();
        mid();
        checkOutput("rvrs_sonuc", sonuc, 32'h0000_ffff);
        checkOutput("rvrs_rd", 32'(rd), 32'd8);

        // SLADD(16,38)=70 then PKG -> 0f0f000f on consecutive cycles
        tick();
        applyStimulus(1, enc(F7, 3'b011, 5'd1, OPC, 10'h0), 32'd16, 32'd38, 1);
        tick();
        applyStimulus(1, enc(F7, 3'b001, 5'd2, OPC, 10'h0), 32'hffff_000f, 32'hffff_0f0f, 1);
        mid();
        checkOutput("b2b_hazir1", 32'(buyruk_hazir), 32'h1);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 1);
        mid();
        checkOutput("b2b_hazir2", 32'(buyruk_hazir), 32'h1);
        checkOutput("sladd_sonuc", sonuc, 32'd70);
        tick();
        mid();
        checkOutput("pkg_sonuc", sonuc, 32'h0f0f_000f);
        checkOutput("pkg_gecerli", 32'(sonuc_gecerli), 32'h1);

        // Writeback stall with both slots full
        tick();
        applyStimulus(1, enc(F7, 3'b101, 5'd3, OPC, 10'h0), 32'h0000_00ff, 32'h0, 0);
        tick();
        applyStimulus(1, enc(F7, 3'b011, 5'd4, OPC, 10'h0), 32'd1, 32'd2, 0);
        mid();
        checkOutput("stall_hazir_bos", 32'(buyruk_hazir), 32'h1);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            mid();
            checkOutput("stall_hazir", 32'(buyruk_hazir), 32'h0);
            checkOutput("stall_sonuc", sonuc, 32'd8);
            checkOutput("stall_rd", 32'(rd), 32'd3);
            tick();
        end
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 1);
        mid();
        checkOutput("release_sonuc1", sonuc, 32'd8);
        tick();
        mid();
        checkOutput("release_sonuc2", sonuc, 32'd4);
        checkOutput("release_rd2", 32'(rd), 32'd4);
        tick();
        mid();
        checkOutput("release_bos", 32'(sonuc_gecerli), 32'h0);

        // Illegal funct3 and illegal opcode
        tick();
        applyStimulus(1, enc(F7, 3'b110, 5'd10, OPC, 10'h0), 32'h1, 32'h2, 1);
        tick();
        applyStimulus(1, enc(F7, 3'b000, 5'd11, 7'b0110011, 10'h0), 32'h1, 32'h2, 1);
        mid();
        checkOutput("ill_pulse1", 32'(gecersiz), 32'h1);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 1);
        mid();
        checkOutput("ill_pulse2", 32'(gecersiz), 32'h1);
        checkOutput("ill_sayac", 32'(gecersiz_sayac), 32'd2);
        tick();
        mid();
        checkOutput("ill_done", 32'(gecersiz), 32'h0);
        checkOutput("ill_no_result", 32'(sonuc_gecerli), 32'h0);

        // Reset with both slots occupied
        tick();
        applyStimulus(1, enc(F7, 3'b101, 5'd5, OPC, 10'h0), 32'h0000_000f, 32'h0, 0);
        tick();
        applyStimulus(1, enc(F7, 3'b101, 5'd6, OPC, 10'h0), 32'h0000_00ff, 32'h0, 0);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 0);
        mid();
        checkOutput("pre_rst_gecerli", 32'(sonuc_gecerli), 32'h1);
        checkOutput("pre_rst_hazir", 32'(buyruk_hazir), 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_gecerli", 32'(sonuc_gecerli), 32'h0);
        checkOutput("midrst_hazir", 32'(buyruk_hazir), 32'h1);
        checkOutput("midrst_tamamlanan", 32'(tamamlanan), 32'h0);
        checkOutput("midrst_sayac", 32'(gecersiz_sayac), 32'h0);
        checkOutput("midrst_sonuc", sonuc, 32'h0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, enc(F7, 3'b100, 5'd9, OPC, 10'h0), 32'h0000_0100, 32'h0, 1);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 1);
        tick();
        mid();
        checkOutput("postrst_gecerli", 32'(sonuc_gecerli), 32'h1);
        checkOutput("postrst_sonuc", sonuc, 32'd8);
        checkOutput("postrst_rd", 32'(rd), 32'd9);
        tick();
        mid();
        checkOutput("postrst_tamamlanan", 32'(tamamlanan), 32'd1);

        // Randomised traffic with random writeback back-pressure
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ins;
            logic [9:0]  rsf;
            logic [2:0]  f3;
            int kind;
            rsf = 10'($urandom());
            kind = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 5));
            case (kind)
                7:       ins = enc(F7, 3'($urandom_range(6, 7)), 5'($urandom()), OPC, rsf);
                8:       ins = enc(F7, f3, 5'($urandom()), 7'b0110011, rsf);
                9:       ins = enc(7'b0000000, f3, 5'($urandom()), OPC, rsf);
                default: ins = enc(F7, f3, 5'($urandom()), OPC, rsf);
            endcase
            applyStimulus($urandom_range(0, 9) < 7, ins, $urandom(), $urandom(), $urandom_range(0, 9) < 7);
            tick();
        end
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 1);
        repeat (5) tick();
        mid();
        if (m_ill >= SAT) checkOutput("ill_saturated", 32'(gecersiz_sayac), 32'(SAT));
        if (m_comp >= SAT) checkOutput("comp_saturated", 32'(tamamlanan), 32'(SAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sifreleme_cozucu_boruhatti.md
Name: sifreleme_cozucu_boruhatti

Overview:
Decode-and-issue stage that sits directly upstream of the combinational sifreleme_birimi in the execute path. It recognises custom crypto instructions and drives the unit's kontrol/deger1/deger2 inputs from a registered issue slot. It captures sonuc back into a result register and hands it to writeback. Both sides use valid/ready handshakes. A saturating counter tracks executed and illegal instructions.

Parameters:
SAYAC_BIT, 16, width of each statistics counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
buyruk_gecerli_i  in  1  upstream instruction valid
buyruk_hazir_o  out  1  this stage can accept an instruction
buyruk_i  in  32  raw instruction word
rs1_deger_i  in  32  rs1 operand value
rs2_deger_i  in  32  rs2 operand value
kontrol_o  out  3  to sifreleme_birimi.kontrol_i
deger1_o  out  32  to sifreleme_birimi.deger1_i
deger2_o  out  32  to sifreleme_birimi.deger2_i
sonuc_i  in  32  from sifreleme_birimi.sonuc_o
sonuc_gecerli_o  out  1  result valid to writeback
sonuc_hazir_i  in  1  writeback ready
sonuc_o  out  32  registered result
rd_o  out  5  destination register of sonuc_o
gecersiz_o  out  1  one-cycle pulse: illegal instruction dropped
tamamlanan_o  out  SAYAC_BIT  results accepted by writeback, saturating
gecersiz_sayac_o  out  SAYAC_BIT  illegal instructions, saturating

Behaviour:
- Reset is asynchronous, active-low. All valids, gecersiz_o, and both counters go to 0. kontrol_o, deger1_o, deger2_o, sonuc_o, and rd_o go to 0.
- Decode:
  - Legal means opcode[6:0] = 7'b0001011 and funct7[31:25] = 7'b0000100.
  - funct3 maps: 000→`SIFRELEME_HMDST; 001→`SIFRELEME_PKG; 010→`SIFRELEME_RVRS; 011→`SIFRELEME_SLADD; 100→`SIFRELEME_CNTZ; 101→`SIFRELEME_CNTP.
  - funct3 110/111 or any other opcode/funct7 is illegal.
- Unary ops (RVRS, CNTZ, CNTP) register deger2 as 32'h0, regardless of rs2_deger_i.
- Issue slot (stage A): registers kontrol, deger1, deger2, rd=buyruk_i[11:7], and A_gecerli. The kontrol_o/deger1_o/deger2_o outputs drive straight from these registers.
- Result slot (stage B): registers sonuc_i, rd, and B_gecerli. sonuc_gecerli_o = B_gecerli.
- Handshake rules:
  - B advances when !B_gecerli or sonuc_hazir_i.
  - A moves to B when A_gecerli and B advances.
  - buyruk_hazir_o = !A_gecerli or (A moves to B). This is combinational; there is no bubble.
- Transfers:
  - Upstream transfer occurs when buyruk_gecerli_i and buyruk_hazir_o.
  - If the instruction is illegal: A is not loaded, gecersiz_o pulses high the next cycle, and gecersiz_sayac_o increments.
  - If legal: A loads.
- Latency:
  - Legal instruction accepted at edge N gives sonuc_gecerli_o high after edge N+1, provided B is free.
  - Sustained throughput is 1 per cycle with continuous readiness.
- Output stability: while sonuc_gecerli_o=1 and sonuc_hazir_i=0, sonuc_o and rd_o hold stable. A holds its contents, so kontrol_o and deger1_o/deger2_o also hold.
- Operand stability: when A is empty, kontrol_o and deger1_o/deger2_o retain their last values; they are don't-care.
- tamamlanan_o increments on each sonuc_gecerli_o and sonuc_hazir_i transfer.
- Both counters saturate at all-ones and do not wrap.
- Simultaneous events: in the same cycle, B can drain to writeback, A can move to B, and a new instruction can load A.
- Reset mid-operation: both in-flight instructions are discarded with no output pulse.

Test Plan:
- Legal HMDST, rs1=32'hf0f0_f0f0, rs2=32'hfff0_f0f0, rd=5, sonuc_hazir_i=1 → kontrol_o=`SIFRELEME_HMDST the cycle after acceptance. One cycle later: sonuc_gecerli_o=1, sonuc_o=4, rd_o=5, tamamlanan_o=1.
- CNTZ with rs1=32'hffff_0000, rs2=32'h1234_5678 → deger2_o=0, sonuc_o=16. RVRS with rs1=32'hffff_0000 → sonuc_o=32'h0000_ffff.
- Back-to-back SLADD(16,38) then PKG(32'hffff_000f, 32'hffff_0f0f), ready held high → consecutive results 70 and 32'h0f0f_000f on consecutive cycles; buyruk_hazir_o stays 1.
- Hold sonuc_hazir_i=0 for 3 cycles with two instructions issued → B and A fill; buyruk_hazir_o=0; sonuc_o stays stable. Release → both results are delivered in order with none lost.
- funct3=110, then opcode 0110011 → gecersiz_o pulses twice, gecersiz_sayac_o=2, no sonuc_gecerli_o.
- Assert rst_ni low with A and B full → all valids 0 immediately and counters 0; after release, the first new instruction completes normally.
